// File: rtl/data_ram_arbiter_if.sv
// data_ram_arbiter_if: core, debug and data-RAM signal bundle for the arbiter.
`default_nettype none

interface data_ram_arbiter_if #(
  parameter int AW = 12
);
  logic          c_req_i;
  logic          c_we_i;
  logic [1:0]    c_size_i;
  logic          c_unsigned_i;
  logic [AW-1:0] c_addr_i;
  logic [31:0]   c_wdata_i;
  logic          c_gnt_o;
  logic          c_rvalid_o;
  logic [31:0]   c_rdata_o;
  logic          c_err_o;

  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [3:0]    d_sel_i;
  logic [31:0]   d_wdata_i;
  logic          d_gnt_o;
  logic          d_rvalid_o;
  logic [31:0]   d_rdata_o;

  logic          ram_we_o;
  logic [3:0]    ram_sel_o;
  logic [AW-1:0] ram_addr_o;
  logic [31:0]   ram_wdata_o;
  logic [31:0]   ram_rdata_i;

  modport slave (
    input  c_req_i, c_we_i, c_size_i, c_unsigned_i, c_addr_i, c_wdata_i,
    output c_gnt_o, c_rvalid_o, c_rdata_o, c_err_o,
    input  d_req_i, d_we_i, d_addr_i, d_sel_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output ram_we_o, ram_sel_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output c_req_i, c_we_i, c_size_i, c_unsigned_i, c_addr_i, c_wdata_i,
    input  c_gnt_o, c_rvalid_o, c_rdata_o, c_err_o,
    output d_req_i, d_we_i, d_addr_i, d_sel_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  ram_we_o, ram_sel_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );
endinterface

`default_nettype wire

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: per-cycle core/debug arbitration onto one data RAM port,
// with core lane steering, load extension and a debug anti-starvation counter.
`default_nettype none

module data_ram_arbiter #(
  parameter int AW         = 12,
  parameter int STARVE_MAX = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  data_ram_arbiter_if.slave  bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] r_starve_cnt;
  logic          r_c_rvalid, r_c_err, r_d_rvalid;
  logic [31:0]   r_c_rdata, r_d_rdata;

  logic          w_starved, w_c_bad, w_core_win, w_dbg_win;
  logic [3:0]    w_c_sel;
  logic [31:0]   w_c_wdata, w_shift, w_c_load;

  assign w_starved  = (r_starve_cnt == SW'(STARVE_MAX));
  assign w_c_bad    = (bus.c_size_i == 2'b11) ||
                      (bus.c_size_i == 2'b01 && bus.c_addr_i[0]) ||
                      (bus.c_size_i == 2'b10 && bus.c_addr_i[1:0] != 2'b00);
  // A misaligned core request still wins arbitration; it just never reaches the RAM.
  assign w_core_win = !rst && bus.c_req_i && !(bus.d_req_i && w_starved);
  assign w_dbg_win  = !rst && bus.d_req_i && !w_core_win;

  assign w_shift    = bus.ram_rdata_i >> {bus.c_addr_i[1:0], 3'b000};

  always_comb begin
    w_c_sel   = 4'b1111;
    w_c_wdata = bus.c_wdata_i;
    w_c_load  = bus.ram_rdata_i;
    case (bus.c_size_i)
      2'b00: begin
        w_c_sel   = 4'b0001 << bus.c_addr_i[1:0];
        w_c_wdata = {4{bus.c_wdata_i[7:0]}};
        w_c_load  = bus.c_unsigned_i ? {24'b0, w_shift[7:0]}
                                     : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      2'b01: begin
        w_c_sel   = 4'b0011 << bus.c_addr_i[1:0];
        w_c_wdata = {2{bus.c_wdata_i[15:0]}};
        w_c_load  = bus.c_unsigned_i ? {16'b0, w_shift[15:0]}
                                     : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.c_gnt_o     = w_core_win;
    bus.d_gnt_o     = w_dbg_win;
    bus.ram_we_o    = 1'b0;
    bus.ram_sel_o   = 4'b0000;
    bus.ram_addr_o  = bus.c_addr_i;
    bus.ram_wdata_o = w_c_wdata;
    if (w_dbg_win) begin
      bus.ram_we_o    = bus.d_we_i;
      bus.ram_sel_o   = bus.d_sel_i;
      bus.ram_addr_o  = bus.d_addr_i;
      bus.ram_wdata_o = bus.d_wdata_i;
    end else if (w_core_win && !w_c_bad) begin
      bus.ram_we_o  = bus.c_we_i;
      bus.ram_sel_o = w_c_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (bus.d_req_i && !w_dbg_win) begin
      if (!w_starved) r_starve_cnt <= r_starve_cnt + SW'(1);
    end else begin
      r_starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_rvalid <= 1'b0;
      r_c_err    <= 1'b0;
      r_c_rdata  <= 32'b0;
      r_d_rvalid <= 1'b0;
      r_d_rdata  <= 32'b0;
    end else begin
      r_c_rvalid <= w_core_win;
      r_c_err    <= w_core_win && w_c_bad;
      r_d_rvalid <= w_dbg_win;
      if (w_core_win) r_c_rdata <= (w_c_bad || bus.c_we_i) ? 32'b0 : w_c_load;
      if (w_dbg_win)  r_d_rdata <= bus.d_we_i ? 32'b0 : bus.ram_rdata_i;
    end
  end

  // Responses are forced quiet for the whole reset window, including a pulse already in flight.
  assign bus.c_rvalid_o = r_c_rvalid && !rst;
  assign bus.c_err_o    = r_c_err && !rst;
  assign bus.c_rdata_o  = rst ? 32'b0 : r_c_rdata;
  assign bus.d_rvalid_o = r_d_rvalid && !rst;
  assign bus.d_rdata_o  = rst ? 32'b0 : r_d_rdata;
endmodule

`default_nettype wire
